// File: rtl/ram_burst_ctrl_if.sv
// ram_burst_ctrl_if: client-side request / write-beat / read-beat bus of the RAM burst controller.
`default_nettype none

interface ram_burst_ctrl_if #(
  parameter int Data_width = 32,
  parameter int Addr_width = 7,
  parameter int Len_width  = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [Addr_width-1:0] req_addr;
  logic [Len_width-1:0]  req_len;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [Data_width-1:0] wdata;
  logic                  rdata_valid;
  logic [Data_width-1:0] rdata;
  logic                  rdata_last;

  modport master (
    output req_valid, req_write, req_addr, req_len, wdata_valid, wdata,
    input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wdata_valid, wdata,
    output req_ready, wdata_ready, rdata_valid, rdata, rdata_last
  );
endinterface

`default_nettype wire

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst sequencer for a single-port synchronous RAM (one beat per cycle).
// Optional memory-clear engine enabled by defining RAM_CTRL_CLEAR_EN. Rev 1.0
`default_nettype none

module ram_burst_ctrl #(
  parameter int Data_width = 32,
  parameter int Addr_width = 7,
  parameter int Len_width  = 4
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  ram_burst_ctrl_if.slave            bus,
  output logic                       busy,
  input  wire logic                  clr_start,
  output logic                       clr_done,
  output logic                       ram_we,
  output logic [Addr_width-1:0]      ram_address,
  output logic [Data_width-1:0]      ram_d,
  input  wire logic [Data_width-1:0] ram_q
);

  localparam logic [Addr_width-1:0] c_addr_one = 1;
  localparam logic [Len_width-1:0]  c_len_one  = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
`ifdef RAM_CTRL_CLEAR_EN
    S_READ  = 2'd2,
    S_CLEAR = 2'd3
`else
    S_READ  = 2'd2
`endif
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [Addr_width-1:0] r_addr, w_addr_nxt;
  logic [Len_width-1:0]  r_beats, w_beats_nxt;
  logic                  r_rd_valid, r_rd_last, r_clr_done;
  logic                  w_rd_issue, w_rd_last, w_clr_fin;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_beats    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_beats    <= w_beats_nxt;
      r_rd_valid <= w_rd_issue;
      r_rd_last  <= w_rd_last;
      r_clr_done <= w_clr_fin;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_beats_nxt     = r_beats;
    w_rd_issue      = 1'b0;
    w_rd_last       = 1'b0;
    w_clr_fin       = 1'b0;
    bus.req_ready   = 1'b0;
    bus.wdata_ready = 1'b0;
    ram_we          = 1'b0;
    ram_d           = bus.wdata;

    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
`ifdef RAM_CTRL_CLEAR_EN
        // A pending clear outranks any request presented in the same cycle.
        if (clr_start) begin
          bus.req_ready = 1'b0;
          w_addr_nxt    = '0;
          w_state_nxt   = S_CLEAR;
        end else
`endif
        if (bus.req_valid) begin
          w_addr_nxt  = bus.req_addr;
          w_beats_nxt = bus.req_len;
          w_state_nxt = bus.req_write ? S_WRITE : S_READ;
        end
      end

      S_WRITE: begin
        bus.wdata_ready = 1'b1;
        ram_we          = bus.wdata_valid;
        if (bus.wdata_valid) begin
          w_addr_nxt  = r_addr + c_addr_one;
          w_beats_nxt = r_beats - c_len_one;
          if (r_beats == '0) w_state_nxt = S_IDLE;
        end
      end

      S_READ: begin
        w_rd_issue  = 1'b1;
        w_addr_nxt  = r_addr + c_addr_one;
        w_beats_nxt = r_beats - c_len_one;
        if (r_beats == '0) begin
          w_rd_last   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

`ifdef RAM_CTRL_CLEAR_EN
      S_CLEAR: begin
        ram_we     = 1'b1;
        ram_d      = '0;
        w_addr_nxt = r_addr + c_addr_one;
        // The address counter doubles as the clear counter; all-ones is the final word.
        if (r_addr == '1) begin
          w_clr_fin   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
`endif

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign ram_address     = r_addr;
  assign busy            = (r_state != S_IDLE);
  assign bus.rdata       = ram_q;
  assign bus.rdata_valid = r_rd_valid;
  assign bus.rdata_last  = r_rd_last;

`ifdef RAM_CTRL_CLEAR_EN
  assign clr_done = r_clr_done;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_start ^ r_clr_done;
  assign clr_done     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Burst access controller that drives the port of a single-port synchronous RAM (`Data_width` x 2^`Addr_width`, write-enable, registered read data, one-cycle read latency). It accepts read or write burst requests over a valid/ready handshake and sequences the RAM's `we`/`address`/`d` pins one beat per cycle. It also returns read data with a last-beat marker. It sits between datapath clients and the RAM macro, and is the only master of that RAM port.

## Interface
- `Data_width`, 32, bits per word
- `Addr_width`, 7, RAM address bits (depth 2^`Addr_width`)
- `Len_width`, 4, burst length field width; burst = `req_len`+1 beats
- `clk` in 1: rising-edge clock
- `reset` in 1: synchronous, active-high reset
- `req_valid` in 1: request present
- `req_ready` out 1: request accepted when `req_valid && req_ready`
- `req_write` in 1: 1 = write burst, 0 = read burst
- `req_addr` in `Addr_width`: start address
- `req_len` in `Len_width`: beats minus one
- `wdata_valid` in 1: write beat present
- `wdata_ready` out 1: write beat consumed when both high
- `wdata` in `Data_width`: write beat data
- `rdata_valid` out 1: read beat valid (no backpressure)
- `rdata` out `Data_width`: read beat data
- `rdata_last` out 1: final beat of read burst
- `busy` out 1: state != IDLE
- `clr_start` in 1: start memory clear (see Configuration)
- `clr_done` out 1: one-cycle pulse, clear finished
- `ram_we` out 1: to RAM `we`
- `ram_address` out `Addr_width`: to RAM `address`
- `ram_d` out `Data_width`: to RAM `d`
- `ram_q` in `Data_width`: from RAM `q`

## Operation
- FSM states: IDLE, WRITE, READ, CLEAR.
- IDLE: `req_ready`=1 (0 if `clr_start` high with clear enabled). On accept: address counter <= `req_addr`, beat counter <= `req_len`, go to WRITE or READ per `req_write`.
- WRITE: `wdata_ready`=1; `ram_we` = `wdata_valid`; `ram_d` = `wdata`. Each accepted beat increments address and decrements the beat counter. The last beat (counter 0) returns to IDLE. `wdata_valid` low stalls without writing.
- READ: `ram_we`=0, one address issued every cycle, no stalls. The last issue returns to IDLE.
- `rdata` = `ram_q` (pass-through). `rdata_valid`/`rdata_last` are registered copies of "read issued"/"last read issued".
- Address arithmetic is modulo 2^`Addr_width`: 127 + 1 wraps to 0 silently; bursts may cross the wrap.
- `wdata_ready`=0 outside WRITE; `ram_we`=0 outside WRITE/CLEAR.
- `ram_address` always equals the address counter.
- Reset (any state, mid-burst included): state IDLE, address/beat counters 0, `rdata_valid`=0, `rdata_last`=0, `clr_done`=0, `busy`=0. Outputs derived from IDLE: `req_ready`=1, `wdata_ready`=0, `ram_we`=0, `ram_address`=0. Any in-flight burst is abandoned; RAM contents already written are kept.

## Timing
- Accept at edge E0; first RAM access occurs in the cycle after E0.
- Read latency: address issued in cycle N, `rdata_valid`=1 with data in cycle N+1. A burst of L beats yields L consecutive valid cycles.
- A write in cycle N is visible to a read issued in cycle N+1 or later.
- Back-to-back: a new request may be accepted in the IDLE cycle that carries the previous read burst's last `rdata_valid`.
- Minimum request-to-request spacing is L+1 cycles.

## Configuration
- `RAM_CTRL_CLEAR_EN` defined:
  - In IDLE, `clr_start`=1 has priority over `req_valid`: go to CLEAR with address 0.
  - CLEAR: `ram_we`=1, `ram_d`=0, address increments every cycle for 2^`Addr_width` cycles, then returns to IDLE.
  - `clr_done` pulses in the first IDLE cycle after CLEAR.
  - `clr_start` is ignored outside IDLE.
- `RAM_CTRL_CLEAR_EN` undefined: CLEAR state absent, `clr_start` ignored, `clr_done` tied 0, `ram_d` = `wdata` always.

## Test plan
- Write burst addr 0x10, len 3, data 0xA0..0xA3 with `wdata_valid` low for one cycle mid-burst -> exactly 4 `ram_we` pulses at 0x10..0x13; `req_ready` returns after the 4th.
- Read burst addr 0x10, len 3 -> `rdata_valid` for 4 consecutive cycles starting 2 cycles after accept, data 0xA0..0xA3, `rdata_last` only on 0xA3.
- Write len 2 at 0x7F -> writes land at 0x7F, 0x00, 0x01; a read-back returns the same order.
- `reset` asserted during the 2nd beat of a len-7 write -> next cycle IDLE, `ram_we`=0, `ram_address`=0; earlier beat retained in RAM.
- Clear enabled: `clr_start` and `req_valid` high together -> 128 zero writes, `clr_done` pulse, then request accepted; read of 0x10 returns 0.
- Write then immediate read request of same address -> read returns new data.
